phase_cfo_avg: RTL

- Downstream consumer of the phase (atan) stage in the OFDM receiver.
- Averages a window of phase samples of the delayed autocorrelation, then scales by the correlation lag. The result is the per-sample rotation used for CFO correction.
- Window start is triggered by the sync/detection logic. Produces one estimate per window.

---
 rtl/phase_cfo_avg.sv | 109 ++++++++++
 1 files changed

// File: rtl/phase_cfo_avg.sv
// phase_cfo_avg: CFO estimator back end for the OFDM receiver.
// Averages 2^WINDOW_SHIFT phase samples of the delayed autocorrelation.
// It then divides by the correlation lag (2^DELAY_SHIFT) to get the per-sample
// rotation used for CFO correction. The sync logic starts each window with `start`.
// The block produces one estimate per window.
//
// Ports:
//   clock            system clock
//   reset            asynchronous active-low reset
//   enable           clock enable; low freezes all state (output_strobe drops)
//   start            begins or restarts a window (same-cycle strobe = sample 1)
//   phase_in         signed phase, [-pi, pi) scaled by 512 (PI = 1608)
//   phase_in_strobe  phase_in valid
//   cfo_phase        signed per-sample rotation, same scaling; held between windows
//   output_strobe    one-cycle pulse when cfo_phase is updated
//   busy             high while a window is accumulating or finishing

module phase_cfo_avg #(
    parameter int WINDOW_SHIFT = 4,
    parameter int DELAY_SHIFT  = 4,
    parameter int ACC_WIDTH    = 32 + WINDOW_SHIFT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               start,
    input  logic signed [31:0] phase_in,
    input  logic               phase_in_strobe,
    output logic signed [31:0] cfo_phase,
    output logic               output_strobe,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH, OUTPUT} state_t;

    localparam logic [WINDOW_SHIFT:0] WIN_LEN = {1'b1, {WINDOW_SHIFT{1'b0}}};
    localparam logic [WINDOW_SHIFT:0] ONE     = {{WINDOW_SHIFT{1'b0}}, 1'b1};

    state_t                      state, state_nxt;
    logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
    logic signed [ACC_WIDTH-1:0] phase_ext, avg, cfo;
    logic        [WINDOW_SHIFT:0] count, count_nxt;
    logic signed [31:0]          cfo_nxt;
    logic                        strobe_nxt;

    assign phase_ext = {{(ACC_WIDTH-32){phase_in[31]}}, phase_in};

    // Both divisions are power-of-two arithmetic shifts, so they round toward -inf.
    assign avg = acc >>> WINDOW_SHIFT;
    assign cfo = avg >>> DELAY_SHIFT;

    // The strobe cycle still counts as busy, so busy drops one cycle after it.
    assign busy = (state != IDLE) | output_strobe;

    always_comb begin
        state_nxt  = state;
        acc_nxt    = acc;
        count_nxt  = count;
        cfo_nxt    = cfo_phase;
        strobe_nxt = 1'b0;
        if (start) begin
            // A start in any state opens a fresh window and drops the old one.
            state_nxt = ACCUM;
            acc_nxt   = phase_in_strobe ? phase_ext : '0;
            count_nxt = phase_in_strobe ? ONE : '0;
        end else begin
            case (state)
                IDLE: ;
                ACCUM: begin
                    if (phase_in_strobe) begin
                        acc_nxt   = acc + phase_ext;
                        count_nxt = count + ONE;
                        if (count_nxt == WIN_LEN) state_nxt = FINISH;
                    end
                end
                FINISH: begin
                    cfo_nxt   = cfo[31:0];
                    state_nxt = OUTPUT;
                end
                OUTPUT: begin
                    // The strobe is issued on the edge that leaves OUTPUT. If enable is
                    // low while in OUTPUT, the pulse waits rather than being lost.
                    strobe_nxt = 1'b1;
                    state_nxt  = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            acc           <= '0;
            count         <= '0;
            cfo_phase     <= '0;
            output_strobe <= 1'b0;
        end else if (enable) begin
            state         <= state_nxt;
            acc           <= acc_nxt;
            count         <= count_nxt;
            cfo_phase     <= cfo_nxt;
            output_strobe <= strobe_nxt;
        end else begin
            output_strobe <= 1'b0;
        end
    end

endmodule
